pmem_arbiter: RTL and testbench

//  Shares the single physical-memory line port between the I-cache and D-cache controllers.

---
 rtl/pmem_arbiter_pkg.sv | 18 +
 rtl/pmem_arbiter_if.sv | 22 ++
 rtl/pmem_arbiter.sv | 119 +++++++++++
 tb/tb_pmem_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pmem_arbiter_pkg.sv
// rtl/pmem_arbiter_pkg.sv - shared types for the physical-memory line port arbiter
package pmem_arb_pkg;

    localparam int PMEM_ADDR_W = 32;
    localparam int PMEM_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } pmem_arb_state_t;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } pmem_client_t;

endpackage

// File: rtl/pmem_arbiter_if.sv
// rtl/pmem_arbiter_if.sv - one cache-line memory port; master issues requests, slave answers
interface pmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/pmem_arbiter.sv
// rtl/pmem_arbiter.sv - round-robin I/D cache arbiter for the physical-memory line port
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    pmem_arbiter_if.slave  i_bus,
    pmem_arbiter_if.slave  d_bus,
    pmem_arbiter_if.master mem_bus
);

    pmem_arb_state_t   state_q, state_d;
    pmem_client_t      rr_last_q, rr_last_d;
    logic              wb_lock_q, wb_lock_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    logic i_req, d_req, pick_i, pick_d;

    // The I-cache never writes back; its write-side inputs are intentionally ignored.
    logic unused_i_write;
    assign unused_i_write = ^{i_bus.pmem_write, i_bus.pmem_wdata};

    assign i_req = i_bus.pmem_read;
    assign d_req = d_bus.pmem_read | d_bus.pmem_write;

    // Next-state: choose a winner in IDLE, hold the grant until memory answers.
    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        wb_lock_d = wb_lock_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pick_i    = 1'b0;
        pick_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending write-back lock lets the D-cache fill follow its eviction unbroken.
                if (wb_lock_q && d_req)    pick_d = 1'b1;
                else if (d_req && !i_req)  pick_d = 1'b1;
                else if (i_req && !d_req)  pick_i = 1'b1;
                else if (i_req && d_req) begin
                    if (rr_last_q == ICACHE) pick_d = 1'b1;
                    else                     pick_i = 1'b1;
                end

                if (pick_d) begin
                    state_d   = GRANT_D;
                    rr_last_d = DCACHE;
                    wb_lock_d = 1'b0;
                    addr_d    = d_bus.pmem_address;
                    wdata_d   = d_bus.pmem_wdata;
                    wr_d      = d_bus.pmem_write;
                    rd_d      = ~d_bus.pmem_write;
                end else if (pick_i) begin
                    state_d   = GRANT_I;
                    rr_last_d = ICACHE;
                    wb_lock_d = 1'b0;
                    addr_d    = i_bus.pmem_address;
                    wr_d      = 1'b0;
                    rd_d      = 1'b1;
                end else if (!d_req) begin
                    wb_lock_d = 1'b0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_bus.pmem_resp) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (state_q == GRANT_D && wr_q) wb_lock_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered memory-side request, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rr_last_q <= ICACHE;
            wb_lock_q <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            wb_lock_q <= wb_lock_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign mem_bus.pmem_read    = rd_q;
    assign mem_bus.pmem_write   = wr_q;
    assign mem_bus.pmem_address = addr_q;
    assign mem_bus.pmem_wdata   = wdata_q;

    // Route memory's completion to the granted client only; line data is shared.
    always_comb begin
        i_bus.pmem_resp  = (state_q == GRANT_I) && mem_bus.pmem_resp;
        d_bus.pmem_resp  = (state_q == GRANT_D) && mem_bus.pmem_resp;
        i_bus.pmem_rdata = mem_bus.pmem_rdata;
        d_bus.pmem_rdata = mem_bus.pmem_rdata;
    end

endmodule

// File: tb/tb_pmem_arbiter.sv
// tb/tb_pmem_arbiter.sv - directed self-checking bench for pmem_arbiter
module tb_pmem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    int   waited;

    pmem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) i_bus ();
    pmem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) d_bus ();
    pmem_arbiter_if #(.ADDR_W(32), .LINE_W(256)) mem_bus ();

    pmem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_bus   (i_bus),
        .d_bus   (d_bus),
        .mem_bus (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for a grant, check the request, answer after lat cycles, check the response pulse.
    task automatic serve(input string tag, input logic exp_d, input logic [31:0] exp_addr,
                         input logic exp_wr, input logic [255:0] exp_wdata, input int lat,
                         input logic [255:0] rdata, input logic drop, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_bus.pmem_read || mem_bus.pmem_write) && n < 20);
        chk({tag, "_granted"}, 256'(mem_bus.pmem_read | mem_bus.pmem_write), 256'd1);
        chk({tag, "_addr"}, 256'(mem_bus.pmem_address), 256'(exp_addr));
        chk({tag, "_wr"}, 256'(mem_bus.pmem_write), 256'(exp_wr));
        chk({tag, "_rd"}, 256'(mem_bus.pmem_read), 256'(!exp_wr));
        if (exp_wr) chk({tag, "_wdata"}, mem_bus.pmem_wdata, exp_wdata);
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        chk({tag, "_addr_held"}, 256'(mem_bus.pmem_address), 256'(exp_addr));
        @(posedge clk); #1;
        mem_bus.pmem_resp  = 1'b1;
        mem_bus.pmem_rdata = rdata;
        @(negedge clk);
        chk({tag, "_i_resp"}, 256'(i_bus.pmem_resp), 256'(!exp_d));
        chk({tag, "_d_resp"}, 256'(d_bus.pmem_resp), 256'(exp_d));
        chk({tag, "_rdata"}, exp_d ? d_bus.pmem_rdata : i_bus.pmem_rdata, rdata);
        @(posedge clk); #1;
        mem_bus.pmem_resp = 1'b0;
        if (drop) begin
            if (exp_d) begin
                d_bus.pmem_read  = 1'b0;
                d_bus.pmem_write = 1'b0;
            end else begin
                i_bus.pmem_read = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, "_resp_pulse"}, 256'(i_bus.pmem_resp | d_bus.pmem_resp), 256'd0);
        chk({tag, "_idle_gap"}, 256'(mem_bus.pmem_read | mem_bus.pmem_write), 256'd0);
    endtask

    initial begin
        rst_n               = 1'b0;
        i_bus.pmem_read     = 1'b0;
        i_bus.pmem_write    = 1'b0;
        i_bus.pmem_address  = '0;
        i_bus.pmem_wdata    = '0;
        d_bus.pmem_read     = 1'b0;
        d_bus.pmem_write    = 1'b0;
        d_bus.pmem_address  = '0;
        d_bus.pmem_wdata    = '0;
        mem_bus.pmem_resp   = 1'b0;
        mem_bus.pmem_rdata  = '0;

        // Reset state
        @(negedge clk);
        chk("rst_read", 256'(mem_bus.pmem_read), 256'd0);
        chk("rst_write", 256'(mem_bus.pmem_write), 256'd0);
        chk("rst_addr", 256'(mem_bus.pmem_address), 256'd0);
        chk("rst_wdata", mem_bus.pmem_wdata, 256'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_req", 256'(mem_bus.pmem_read | mem_bus.pmem_write), 256'd0);

        // 1: I-cache alone, one-cycle request latency
        @(posedge clk); #1;
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_1000;
        @(negedge clk);
        chk("t1_cycle_n", 256'(mem_bus.pmem_read), 256'd0);
        serve("t1", 1'b0, 32'h0000_1000, 1'b0, '0, 5, {8{32'hA1A1_0001}}, 1'b1, waited);
        chk("t1_latency", 256'(waited), 256'd1);

        // 2: tie straight from reset goes to D, then I after one idle cycle
        @(posedge clk); #1;
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_1100;
        d_bus.pmem_read    = 1'b1;
        d_bus.pmem_address = 32'h0000_3000;
        serve("t2_d", 1'b1, 32'h0000_3000, 1'b0, '0, 2, {8{32'hB2B2_0002}}, 1'b1, waited);
        serve("t2_i", 1'b0, 32'h0000_1100, 1'b0, '0, 2, {8{32'hC3C3_0003}}, 1'b1, waited);
        chk("t2_i_after_gap", 256'(waited), 256'd1);

        // 3: continuous requests from both alternate D, I, D, I
        @(posedge clk); #1;
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_1200;
        d_bus.pmem_read    = 1'b1;
        d_bus.pmem_address = 32'h0000_3100;
        serve("t3_d0", 1'b1, 32'h0000_3100, 1'b0, '0, 1, {8{32'hD4D4_0004}}, 1'b0, waited);
        serve("t3_i1", 1'b0, 32'h0000_1200, 1'b0, '0, 1, {8{32'hE5E5_0005}}, 1'b0, waited);
        serve("t3_d2", 1'b1, 32'h0000_3100, 1'b0, '0, 1, {8{32'hF6F6_0006}}, 1'b0, waited);
        serve("t3_i3", 1'b0, 32'h0000_1200, 1'b0, '0, 1, {8{32'h0707_0007}}, 1'b1, waited);
        d_bus.pmem_read = 1'b0;

        // 4: write-back then fill stays atomic ahead of a waiting I-cache read
        @(posedge clk); #1;
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_1300;
        d_bus.pmem_write   = 1'b1;
        d_bus.pmem_address = 32'h0000_2000;
        d_bus.pmem_wdata   = {8{32'hDEAD_BEEF}};
        serve("t4_dwr", 1'b1, 32'h0000_2000, 1'b1, {8{32'hDEAD_BEEF}}, 3, '0, 1'b1, waited);
        d_bus.pmem_read    = 1'b1;
        d_bus.pmem_address = 32'h0000_4000;
        serve("t4_drd", 1'b1, 32'h0000_4000, 1'b0, '0, 2, {8{32'h1818_0008}}, 1'b1, waited);
        serve("t4_ird", 1'b0, 32'h0000_1300, 1'b0, '0, 2, {8{32'h2929_0009}}, 1'b1, waited);

        // 5: read and write both high on the D side is a write
        @(posedge clk); #1;
        d_bus.pmem_read    = 1'b1;
        d_bus.pmem_write   = 1'b1;
        d_bus.pmem_address = 32'h0000_5000;
        d_bus.pmem_wdata   = {8{32'h5A5A_A5A5}};
        serve("t5", 1'b1, 32'h0000_5000, 1'b1, {8{32'h5A5A_A5A5}}, 2, '0, 1'b1, waited);

        // 6: asynchronous reset in the middle of an I-cache grant
        @(posedge clk); #1;
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_6000;
        repeat (2) @(negedge clk);
        chk("t6_granted", 256'(mem_bus.pmem_read), 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_read", 256'(mem_bus.pmem_read), 256'd0);
        chk("t6_async_addr", 256'(mem_bus.pmem_address), 256'd0);
        mem_bus.pmem_resp = 1'b1;
        #1;
        chk("t6_no_i_resp", 256'(i_bus.pmem_resp), 256'd0);
        @(posedge clk); #1;
        mem_bus.pmem_resp = 1'b0;
        i_bus.pmem_read   = 1'b0;
        rst_n             = 1'b1;
        @(negedge clk);
        chk("t6_idle_after", 256'(mem_bus.pmem_read | mem_bus.pmem_write), 256'd0);

        // After reset the D-cache again wins a tie
        @(posedge clk); #1;
        i_bus.pmem_read    = 1'b1;
        i_bus.pmem_address = 32'h0000_1400;
        d_bus.pmem_read    = 1'b1;
        d_bus.pmem_address = 32'h0000_7000;
        serve("t6_tie", 1'b1, 32'h0000_7000, 1'b0, '0, 1, {8{32'h7B7B_000B}}, 1'b1, waited);
        serve("t6_next", 1'b0, 32'h0000_1400, 1'b0, '0, 1, {8{32'h8C8C_000C}}, 1'b1, waited);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
